// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcode encoding, mul/div
// sequencer states, default iteration count and opcode class helpers.
package ex_pkg;

    localparam int MD_CYCLES_DEFAULT = 32;

    typedef enum logic [4:0] {
        ALU_ADD,  ALU_ADDU, ALU_SUB,   ALU_SUBU,
        ALU_AND,  ALU_OR,   ALU_XOR,   ALU_NOR,
        ALU_SLT,  ALU_SLTU, ALU_SLL,   ALU_SRL,
        ALU_SRA,  ALU_SLLV, ALU_SRLV,  ALU_SRAV,
        ALU_LUI,  ALU_MULT, ALU_MULTU, ALU_DIV,
        ALU_DIVU, ALU_MFHI, ALU_MFLO,  ALU_MTHI,
        ALU_MTLO
    } alu_op_e;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    // Ops that read or write HI/LO, or start the mul/div unit.
    function automatic logic is_hilo_op(input alu_op_e op);
        return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU,
                          ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO};
    endfunction

    function automatic logic is_md_op(input alu_op_e op);
        return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative multiply/divide unit owning HI/LO. One bit per cycle on operand
// magnitudes (shift-add multiply, restoring divide); signs are fixed up when
// the last iteration writes HI/LO.
// Ports:
//   clk, rst            clock, synchronous active-high reset (aborts op)
//   i_start             launch MULT/MULTU/DIV/DIVU given by i_op
//   i_op                operation code (ex_pkg::alu_op_e encoding)
//   i_opa, i_opb        rs / rt operands
//   i_mthi, i_mtlo      direct HI/LO write with i_wdata
//   o_busy              iteration in progress
//   o_hi, o_lo          HI/LO registers
//
// state   | meaning
// MD_IDLE | no operation running, HI/LO writable by MTHI/MTLO
// MD_BUSY | iterating, r_cnt counts down to terminal count 1
module ex_muldiv_iter
    import ex_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [4:0]  i_op,
    input  logic [31:0] i_opa,
    input  logic [31:0] i_opb,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam int CW = $clog2(MD_CYCLES + 1);

    md_state_e     r_state;
    md_state_e     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          w_cnt_tc;
    logic          r_is_div;
    logic          r_neg_q;
    logic          r_neg_r;
    logic [31:0]   r_b;
    logic [31:0]   r_q;
    logic [31:0]   r_acc;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    alu_op_e       w_op;
    logic          w_signed;
    logic          w_div;
    logic          w_a_neg;
    logic          w_b_neg;
    logic [31:0]   w_a_mag;
    logic [31:0]   w_b_mag;

    logic [32:0]   w_msum;
    logic [32:0]   w_dshift;
    logic [31:0]   w_dsub;
    logic          w_dge;
    logic [31:0]   w_acc_nxt;
    logic [31:0]   w_q_nxt;
    logic [63:0]   w_prod;
    logic [63:0]   w_prod_fix;
    logic [31:0]   w_quo;
    logic [31:0]   w_rem;
    logic [31:0]   w_hi_res;
    logic [31:0]   w_lo_res;

    assign w_op     = alu_op_e'(i_op);
    assign w_signed = (w_op == ALU_MULT) || (w_op == ALU_DIV);
    assign w_div    = (w_op == ALU_DIV) || (w_op == ALU_DIVU);
    assign w_a_neg  = w_signed & i_opa[31];
    assign w_b_neg  = w_signed & i_opb[31];
    assign w_a_mag  = w_a_neg ? (~i_opa + 32'd1) : i_opa;
    assign w_b_mag  = w_b_neg ? (~i_opb + 32'd1) : i_opb;
    assign w_cnt_tc = (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (i_start)  w_state_nxt = MD_BUSY;
            MD_BUSY: if (w_cnt_tc) w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == MD_BUSY);
    end

    // Multiply: r_q holds the multiplier and shifts right while the product
    // high half accumulates in r_acc. Divide: r_q holds the dividend and
    // collects quotient bits, r_acc is the partial remainder.
    assign w_msum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : 33'd0);
    assign w_dshift = {r_acc, r_q[31]};
    assign w_dge    = (w_dshift >= {1'b0, r_b});
    // When w_dge holds the true difference is below r_b, so 32 bits suffice.
    assign w_dsub   = w_dshift[31:0] - r_b;

    always_comb begin
        if (r_is_div) begin
            w_acc_nxt = w_dge ? w_dsub : w_dshift[31:0];
            w_q_nxt   = {r_q[30:0], w_dge};
        end else begin
            w_acc_nxt = w_msum[32:1];
            w_q_nxt   = {w_msum[0], r_q[31:1]};
        end
    end

    assign w_prod     = {w_acc_nxt, w_q_nxt};
    assign w_prod_fix = r_neg_q ? (~w_prod + 64'd1) : w_prod;
    assign w_quo      = r_neg_q ? (~w_q_nxt + 32'd1) : w_q_nxt;
    assign w_rem      = r_neg_r ? (~w_acc_nxt + 32'd1) : w_acc_nxt;
    assign w_hi_res   = r_is_div ? w_rem : w_prod_fix[63:32];
    assign w_lo_res   = r_is_div ? w_quo : w_prod_fix[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b      <= '0;
            r_q      <= '0;
            r_acc    <= '0;
        end else if (i_start && !o_busy) begin
            r_cnt    <= CW'(MD_CYCLES);
            r_is_div <= w_div;
            // A zero divisor must leave an all-ones quotient untouched.
            r_neg_q  <= (w_a_neg ^ w_b_neg) & ~(w_div & (i_opb == 32'd0));
            r_neg_r  <= w_div & w_a_neg;
            r_b      <= w_div ? w_b_mag : w_a_mag;
            r_q      <= w_div ? w_a_mag : w_b_mag;
            r_acc    <= '0;
        end else if (o_busy) begin
            r_cnt    <= r_cnt - CW'(1);
            r_q      <= w_q_nxt;
            r_acc    <= w_acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (o_busy && w_cnt_tc) begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
        end else begin
            if (i_mthi) r_hi <= i_wdata;
            if (i_mtlo) r_lo <= i_wdata;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/ex_alu_muldiv.sv
// Execute stage: single-cycle ALU plus optional iterative mul/div unit with
// HI/LO. Results are registered (latency 1). Build macro EX_MULDIV_EN enables
// the mul/div unit; without it HI/LO ops complete as no-write with result 0.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_in, alu_op         op present / opcode (ex_pkg::alu_op_e)
//   data_1, data_2, imm      rs, rt, extended immediate
//   alu_src, shamt           operand B select, fixed shift amount
//   rd_in, reg_write_in      destination and write enable
//   stall_out                combinational hold request to ID
//   valid_out, result        registered result
//   rd_out, reg_write_out    registered destination / write enable
//   ovf_out                  registered ADD/SUB signed overflow
//   md_busy, hi, lo          mul/div status and HI/LO registers
module ex_alu_muldiv
    import ex_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [4:0]  alu_op,
    input  logic [31:0] data_1,
    input  logic [31:0] data_2,
    input  logic [31:0] imm,
    input  logic        alu_src,
    input  logic [4:0]  shamt,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        ovf_out,
    output logic        md_busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    alu_op_e     w_op;
    logic [31:0] w_opb;
    logic        w_hilo;
    logic        w_accept;
    logic        w_md_busy;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_alu_res;
    logic        w_ovf;
    logic        w_rw_ok;

    logic        r_valid;
    logic [31:0] r_result;
    logic [4:0]  r_rd;
    logic        r_rw;
    logic        r_ovf;

    assign w_op   = alu_op_e'(alu_op);
    assign w_opb  = alu_src ? imm : data_2;
    assign w_hilo = is_hilo_op(w_op);
    assign w_sum  = data_1 + w_opb;
    assign w_diff = data_1 - w_opb;

`ifdef EX_MULDIV_EN
    logic w_md_start;
    logic w_mthi;
    logic w_mtlo;

    assign stall_out  = valid_in & w_md_busy & w_hilo;
    assign w_accept   = valid_in & ~stall_out;
    assign w_md_start = w_accept & is_md_op(w_op);
    assign w_mthi     = w_accept & (w_op == ALU_MTHI);
    assign w_mtlo     = w_accept & (w_op == ALU_MTLO);
    // MFHI/MFLO are the only HI/LO ops that write the register file.
    assign w_rw_ok    = ~w_hilo | (w_op == ALU_MFHI) | (w_op == ALU_MFLO);

    ex_muldiv_iter #(
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_md_start),
        .i_op    (alu_op),
        .i_opa   (data_1),
        .i_opb   (data_2),
        .i_mthi  (w_mthi),
        .i_mtlo  (w_mtlo),
        .i_wdata (data_1),
        .o_busy  (w_md_busy),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );
`else
    // Iteration count only matters when the mul/div unit is built.
    logic w_unused_md_cycles;
    assign w_unused_md_cycles = (MD_CYCLES != 0);

    assign stall_out = 1'b0;
    assign w_accept  = valid_in;
    assign w_md_busy = 1'b0;
    assign w_hi      = '0;
    assign w_lo      = '0;
    assign w_rw_ok   = ~w_hilo;
`endif

    always_comb begin
        w_alu_res = '0;
        w_ovf     = 1'b0;
        case (w_op)
            ALU_ADD: begin
                w_alu_res = w_sum;
                w_ovf     = (data_1[31] == w_opb[31]) && (w_sum[31] != data_1[31]);
            end
            ALU_SUB: begin
                w_alu_res = w_diff;
                w_ovf     = (data_1[31] != w_opb[31]) && (w_diff[31] != data_1[31]);
            end
            ALU_ADDU: w_alu_res = w_sum;
            ALU_SUBU: w_alu_res = w_diff;
            ALU_AND:  w_alu_res = data_1 & w_opb;
            ALU_OR:   w_alu_res = data_1 | w_opb;
            ALU_XOR:  w_alu_res = data_1 ^ w_opb;
            ALU_NOR:  w_alu_res = ~(data_1 | w_opb);
            ALU_SLT:  w_alu_res = {31'd0, $signed(data_1) < $signed(w_opb)};
            ALU_SLTU: w_alu_res = {31'd0, data_1 < w_opb};
            ALU_SLL:  w_alu_res = data_2 << shamt;
            ALU_SRL:  w_alu_res = data_2 >> shamt;
            ALU_SRA:  w_alu_res = $unsigned($signed(data_2) >>> shamt);
            ALU_SLLV: w_alu_res = data_2 << data_1[4:0];
            ALU_SRLV: w_alu_res = data_2 >> data_1[4:0];
            ALU_SRAV: w_alu_res = $unsigned($signed(data_2) >>> data_1[4:0]);
            ALU_LUI:  w_alu_res = {imm[15:0], 16'h0000};
            ALU_MFHI: w_alu_res = w_hi;
            ALU_MFLO: w_alu_res = w_lo;
            default:  w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
            r_rw     <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_valid <= w_accept;
            r_rw    <= w_accept & reg_write_in & w_rw_ok & ~w_ovf;
            r_ovf   <= w_accept & w_ovf;
            if (w_accept) begin
                r_result <= w_alu_res;
                r_rd     <= rd_in;
            end
        end
    end

    assign valid_out     = r_valid;
    assign result        = r_result;
    assign rd_out        = r_rd;
    assign reg_write_out = r_rw;
    assign ovf_out       = r_ovf;
    assign md_busy       = w_md_busy;
    assign hi            = w_hi;
    assign lo            = w_lo;

endmodule
